clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
//
// PURPOSE
//   Consumes the divided clock (nominally clk_in/3, ~50% duty) as a data signal in the clk_in domain.
//   Synchronises it, emits one-cycle rise strobes usable as clock enables, measures each period in
//   clk_in cycles, and declares lock or fault against an expected ratio.
//   Sits directly downstream of the divide-by-3 stage; drives core clock-enable and health status.
//
// PARAMETERS
//   EXP_PERIOD  3   expected div_clk period in clk_in cycles
//   LOCK_CNT    4   consecutive good measured periods required for lock
//   TIMEOUT     8   clk_in cycles without a rise before a timeout event; must exceed EXP_PERIOD
//   CNT_W       4   width of gap counter and period output; 2^CNT_W-1 >= TIMEOUT
//
// PORTS
//   clk_in      in   1      system clock (undivided)
//   rst_n       in   1      asynchronous active-low reset
//   enable      in   1      1 = monitor runs; 0 = forced to IDLE
//   fault_clr   in   1      one-cycle request to leave FAULT
//   div_clk     in   1      divided clock under test, treated as asynchronous data
//   rise_pulse  out  1      one-cycle strobe per synchronised div_clk rising edge
//   period      out  CNT_W  last measured period (clk_in cycles)
//   lock        out  1      period stable at EXP_PERIOD
//   fault       out  1      sticky: mismatch or timeout while locked
//
// BEHAVIOUR
//   Reset (rst_n=0, async): sync flops, gap counter, good counter, first_seen = 0; state = IDLE.
//     rise_pulse=0, period=0, lock=0, fault=0.
//   Sync: s1 <= div_clk, s2 <= s1, s3 <= s2.
//     rise = s2 & ~s3.
//     rise_pulse = rise, decoded from registers, exactly one cycle wide.
//     rise_pulse is high in the cycle after the 2nd posedge following div_clk going high.
//   Gap counter cnt: +1 each cycle, saturating at 2^CNT_W-1.
//     On rise: cnt <= 0; if first_seen, period <= cnt+1 (measured period).
//     first_seen <= 1 on any rise.
//     The first rise after entering ACQUIRE only sets first_seen; it makes no measurement.
//   Timeout event: no rise and cnt == TIMEOUT-1.
//     If rise and timeout coincide, rise wins: the measurement is taken and no timeout occurs.
//   FSM (state register, updated on posedge clk_in):
//     IDLE: cnt, good, first_seen held at 0; lock=0; fault=0.
//       enable=1 -> ACQUIRE.
//     ACQUIRE: per measured period:
//       period == EXP_PERIOD -> good++; else good <= 0.
//       When good reaches LOCK_CNT -> LOCKED (lock=1 from the next cycle).
//       Timeout -> good <= 0, first_seen <= 0; stay in ACQUIRE, no fault.
//     LOCKED: measured period != EXP_PERIOD, or timeout -> FAULT.
//       On that transition, lock=0 and fault=1 from the next cycle.
//     FAULT: fault=1, lock=0; measurements continue updating period.
//       fault_clr=1 -> ACQUIRE with good=0, first_seen=0; fault=0 from the next cycle.
//   Priority: rst_n > enable=0 (any state -> IDLE next cycle, clears fault) > fault_clr > measurement/timeout.
//   fault_clr outside FAULT is ignored. period holds its value across IDLE and only changes on a measurement.
//   rise_pulse is generated in every state, including IDLE; only the first_seen/measurement logic is gated by state.
//
// TESTING
//   1. Drive div_clk from a live clk_div_by_3 instance, enable=1 -> rise_pulse every 3 cycles;
//      period=3; lock=1 one cycle after the 5th rise (4 measurements).
//   2. Locked, then stretch one div_clk period to 4 cycles -> period=4;
//      fault=1 and lock=0 the cycle after that rise.
//   3. Locked, then hold div_clk low -> fault=1 the cycle after cnt reaches 7;
//      period unchanged at 3.
//   4. In FAULT, pulse fault_clr with a good div_clk -> fault=0 next cycle;
//      lock=1 again after 5 further rises.
//   5. In ACQUIRE with good=3, inject a 2-cycle period -> good resets;
//      lock needs 4 further good measurements.
//   6. Drop rst_n mid-LOCKED for a partial cycle -> all outputs 0 immediately (asynchronous).
//      Separately, enable=0 for one cycle in FAULT -> fault=0, lock=0, and reacquisition follows.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: samples a divided clock as data in the clk_in domain,
// strobes each synchronised rising edge, measures the spacing between rises
// and tracks lock/fault against the expected division ratio.
module clk_div_monitor #(
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fault_clr,
  input  logic             div_clk,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             lock,
  output logic             fault
);

  localparam int unsigned        GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   EXP_P  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]   TMO_C  = CNT_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0]  LOCK_G = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic rise;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              seen_q, seen_d;
  logic [CNT_W-1:0]  period_q, period_d;

  logic              active;
  logic              clr_req;
  logic              meas;
  logic              meas_ok;
  logic              tmo;
  logic [CNT_W-1:0]  meas_val;

  // Three-flop synchroniser; the third stage only serves edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= div_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise       = s2_q & ~s3_q;
  assign rise_pulse = rise;
  assign period     = period_q;

  // Measurement datapath: gap counter, good-period counter, first-rise flag.
  always_comb begin
    active   = enable && (state_q != ST_IDLE);
    clr_req  = active && (state_q == ST_FAULT) && fault_clr;
    meas     = active && !clr_req && rise && seen_q;
    tmo      = active && !clr_req && !rise && (cnt_q == TMO_C);
    // A rise seen with the counter saturated reports the maximum instead of wrapping.
    meas_val = (cnt_q == '1) ? '1 : cnt_q + 1'b1;
    meas_ok  = (meas_val == EXP_P);

    cnt_d = cnt_q;
    if (!active || rise) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    seen_d = seen_q;
    if (!active || clr_req) begin
      seen_d = 1'b0;
    end else if (rise) begin
      seen_d = 1'b1;
    end else if (tmo && (state_q == ST_ACQUIRE)) begin
      seen_d = 1'b0;
    end

    good_d = good_q;
    if (!active || clr_req) begin
      good_d = '0;
    end else if (state_q == ST_ACQUIRE) begin
      if (tmo) begin
        good_d = '0;
      end else if (meas) begin
        good_d = meas_ok ? (good_q + 1'b1) : '0;
      end
    end

    period_d = meas ? meas_val : period_q;
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      good_q   <= '0;
      seen_q   <= 1'b0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      seen_q   <= seen_d;
      period_q <= period_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; enable low overrides everything below reset.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (meas && meas_ok && ((good_q + 1'b1) == LOCK_G)) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if ((meas && !meas_ok) || tmo) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (clr_req) begin
            state_d = ST_ACQUIRE;
          end
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    lock  = (state_q == ST_LOCKED);
    fault = (state_q == ST_FAULT);
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed bench for clk_div_monitor. div_clk is produced
// by the bench as a programmable divider; every rise pushes the expected
// period/lock/fault seen one cycle after the rise strobe.
module tb_clk_div_monitor;

  localparam int unsigned CNT_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fault_clr;
  logic             div_clk;
  logic             rise_pulse;
  logic [CNT_W-1:0] period;
  logic             lock;
  logic             fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int p;
    bit l;
    bit f;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   pend = 1'b0;

  clk_div_monitor #(
    .EXP_PERIOD(3),
    .LOCK_CNT  (4),
    .TIMEOUT   (8),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .fault_clr (fault_clr),
    .div_clk   (div_clk),
    .rise_pulse(rise_pulse),
    .period    (period),
    .lock      (lock),
    .fault     (fault)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One div_clk period of n clk_in cycles starting with a rise; ep/el/ef are
  // the period/lock/fault expected one cycle after this rise's strobe.
  task automatic per(input int n, input int ep, input bit el, input bit ef);
    int   hi;
    exp_t e;
    hi  = (n + 1) / 2;
    e.p = ep;
    e.l = el;
    e.f = ef;
    sb_q.push_back(e);
    div_clk = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == hi) div_clk = 1'b0;
      @(negedge clk_in);
      if (k == 0) chk("rise_early", rise_pulse, 0);
      if (k == 1) chk("rise_on_time", rise_pulse, 1);
    end
  endtask

  // Scoreboard: each observed strobe pops one expectation, checked next cycle.
  always @(negedge clk_in) begin
    if (pend) begin
      pend = 1'b0;
      chk("sb_has_entry", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("rise_period", period, mon_e.p);
        chk("rise_lock", lock, mon_e.l);
        chk("rise_fault", fault, mon_e.f);
      end
    end
    if (rise_pulse === 1'b1) pend = 1'b1;
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    fault_clr = 1'b0;
    div_clk   = 1'b0;
    cyc(2);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_period", period, 0);
    chk("rst_lock", lock, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_lock", lock, 0);
    enable = 1'b1;
    cyc(1);

    // Acquire from a clean divide-by-3: lock after the 5th rise.
    for (int i = 0; i < 6; i++) per(3, (i == 0) ? 0 : 3, i >= 4, 1'b0);

    // Stretched period while locked.
    per(3, 3, 1'b1, 1'b0);
    per(4, 3, 1'b1, 1'b0);
    per(3, 4, 1'b0, 1'b1);
    per(3, 3, 1'b0, 1'b1);

    // Clear the fault and relock.
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("clr_fault", fault, 0);
    chk("clr_lock", lock, 0);
    for (int i = 0; i < 5; i++) per(3, 3, i == 4, 1'b0);

    // div_clk held low while locked: timeout after cnt reaches 7.
    per(3, 3, 1'b1, 1'b0);
    cyc(7);
    chk("tmo_pre_fault", fault, 0);
    chk("tmo_pre_lock", lock, 1);
    cyc(1);
    chk("tmo_fault", fault, 1);
    chk("tmo_lock", lock, 0);
    chk("tmo_period", period, 3);

    // One cycle of enable low from FAULT.
    enable = 1'b0;
    cyc(1);
    chk("dis_fault", fault, 0);
    chk("dis_lock", lock, 0);
    chk("dis_period", period, 3);
    enable = 1'b1;
    cyc(1);

    // Reacquire with a 2-cycle glitch after three good measurements.
    for (int i = 0; i < 3; i++) per(3, 3, 1'b0, 1'b0);
    per(2, 3, 1'b0, 1'b0);
    per(3, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) per(3, 3, 1'b0, 1'b0);
    per(3, 3, 1'b1, 1'b0);

    // Rise coincident with cnt == TIMEOUT-1: measured as 8, not a timeout.
    per(8, 3, 1'b1, 1'b0);
    per(3, 8, 1'b0, 1'b1);
    per(3, 3, 1'b0, 1'b1);

    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    for (int i = 0; i < 5; i++) per(3, 3, i == 4, 1'b0);

    // Asynchronous reset pulse between clock edges while locked.
    chk("pre_rst_lock", lock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rise", rise_pulse, 0);
    chk("arst_period", period, 0);
    chk("arst_lock", lock, 0);
    chk("arst_fault", fault, 0);
    #1 rst_n = 1'b1;
    cyc(1);
    per(3, 0, 1'b0, 1'b0);
    per(3, 3, 1'b0, 1'b0);

    // IDLE: strobes continue, period held, no measurement.
    enable = 1'b0;
    cyc(1);
    chk("idle2_lock", lock, 0);
    chk("idle2_period", period, 3);
    per(4, 3, 1'b0, 1'b0);
    per(3, 3, 1'b0, 1'b0);
    cyc(4);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
